iq_dac_spi: RTL



---
 rtl/iq_dac_spi_if.sv | 22 ++
 rtl/iq_dac_spi.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/iq_dac_spi_if.sv
// Sample input, status and SPI pin bundle between the sample source and the DAC serializer.
interface iq_dac_spi_if;
    logic        enable;
    logic [31:0] mod_iq;
    logic        overrun_clr;
    logic        dac_sclk;
    logic        dac_cs_n;
    logic        dac_mosi;
    logic        dac_ldac_n;
    logic        busy;
    logic        overrun;

    modport master (
        output enable, mod_iq, overrun_clr,
        input  dac_sclk, dac_cs_n, dac_mosi, dac_ldac_n, busy, overrun
    );

    modport slave (
        input  enable, mod_iq, overrun_clr,
        output dac_sclk, dac_cs_n, dac_mosi, dac_ldac_n, busy, overrun
    );
endinterface

// File: rtl/iq_dac_spi.sv
// Dual-channel SPI DAC driver: samples an I/Q pair every SAMPLE_DIV clocks, shifts an I then a Q
// command frame in offset binary, then strobes LDAC so both outputs update together.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a sample tick, outputs parked
// FRAME_I | shifting 24-bit I frame, 2 clocks per bit (sclk low, high)
// GAP     | cs_n high for GAP clocks between frames
// FRAME_Q | shifting 24-bit Q frame
// LDAC    | ldac_n low for 2 clocks, then back to IDLE
module iq_dac_spi #(
    parameter int unsigned SAMPLE_DIV = 128,
    parameter int unsigned GAP        = 2,
    parameter logic [7:0]  CMD_I      = 8'h30,
    parameter logic [7:0]  CMD_Q      = 8'h31
) (
    input logic          clk,
    input logic          rst_n,
    iq_dac_spi_if.slave  bus
);
    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WAIT_W = $clog2(GAP + 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LOAD  = WAIT_W'(GAP - 1);
    localparam logic [WAIT_W-1:0] LDAC_LOAD = WAIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FRAME_I = 3'd1,
        S_GAP     = 3'd2,
        S_FRAME_Q = 3'd3,
        S_LDAC    = 3'd4
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [4:0]          bit_cnt, bit_d;
    logic                phase, phase_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_d;
    logic [23:0]         shift, shift_d;
    logic [15:0]         q_hold, q_hold_d;
    logic                tick;

    logic sclk_q, cs_n_q, mosi_q, ldac_n_q, busy_q, overrun_q;
    logic sclk_d, cs_n_d, mosi_d, ldac_n_d, busy_d, overrun_d;

    assign tick = bus.enable && (cnt == CNT_LAST);

    // State and datapath registers; outputs are registered copies of their next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            wait_cnt  <= '0;
            shift     <= '0;
            q_hold    <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            ldac_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_cnt   <= bit_d;
            phase     <= phase_d;
            wait_cnt  <= wait_d;
            shift     <= shift_d;
            q_hold    <= q_hold_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            ldac_n_q  <= ldac_n_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d  = state;
        bit_d    = bit_cnt;
        phase_d  = phase;
        wait_d   = wait_cnt;
        shift_d  = shift;
        q_hold_d = q_hold;
        cnt_d    = (!bus.enable || tick) ? '0 : cnt + CNT_W'(1);

        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_d  = S_FRAME_I;
                    shift_d  = {CMD_I, ~bus.mod_iq[31], bus.mod_iq[30:16]};
                    q_hold_d = {~bus.mod_iq[15], bus.mod_iq[14:0]};
                    bit_d    = 5'd23;
                    phase_d  = 1'b0;
                end
            end
            S_FRAME_I, S_FRAME_Q: begin
                phase_d = ~phase;
                if (phase) begin
                    shift_d = {shift[22:0], 1'b0};
                    if (bit_cnt == 5'd0) begin
                        state_d = (state == S_FRAME_I) ? S_GAP : S_LDAC;
                        wait_d  = (state == S_FRAME_I) ? GAP_LOAD : LDAC_LOAD;
                    end else begin
                        bit_d = bit_cnt - 5'd1;
                    end
                end
            end
            S_GAP: begin
                if (wait_cnt == '0) begin
                    state_d = S_FRAME_Q;
                    shift_d = {CMD_Q, q_hold};
                    bit_d   = 5'd23;
                    phase_d = 1'b0;
                end else begin
                    wait_d = wait_cnt - WAIT_W'(1);
                end
            end
            S_LDAC: begin
                if (wait_cnt == '0) state_d = S_IDLE;
                else                wait_d  = wait_cnt - WAIT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A tick that finds the serializer busy is dropped; a simultaneous clear loses to it.
    always_comb begin
        logic in_frame;
        in_frame  = (state_d == S_FRAME_I) || (state_d == S_FRAME_Q);
        sclk_d    = in_frame && phase_d;
        cs_n_d    = !in_frame;
        mosi_d    = in_frame && shift_d[23];
        ldac_n_d  = (state_d != S_LDAC);
        busy_d    = (state_d != S_IDLE);
        overrun_d = (tick && (state != S_IDLE)) || (overrun_q && !bus.overrun_clr);
    end

    assign bus.dac_sclk   = sclk_q;
    assign bus.dac_cs_n   = cs_n_q;
    assign bus.dac_mosi   = mosi_q;
    assign bus.dac_ldac_n = ldac_n_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
endmodule
